// File: rtl/exu_seq_pkg.sv
// Shared types and constants for the execute sequencer: widths, ALU opcodes,
// FSM state, arbitration winner and the latched micro-op record.
package exu_seq_pkg;

    localparam int RV_XLEN      = 32;
    localparam int RV_GPR_AW    = 5;
    localparam int RV_GPR_N     = 1 << RV_GPR_AW;
    localparam int ALU_OPC_SIZE = 4;

    localparam logic [ALU_OPC_SIZE-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OPC_SIZE-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OPC_SIZE-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OPC_SIZE-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OPC_SIZE-1:0] ALU_XOR = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } exu_seq_state_e;

    typedef enum logic {
        WIN_ALU = 1'b0,
        WIN_LD  = 1'b1
    } exu_arb_win_e;

    typedef struct packed {
        logic [ALU_OPC_SIZE-1:0] opc;
        logic [RV_GPR_AW-1:0]    rs1;
        logic [RV_GPR_AW-1:0]    rs2;
        logic [RV_GPR_AW-1:0]    rd;
        logic [RV_XLEN-1:0]      imm;
        logic                    use_imm;
        logic                    wen;
    } exu_uop_t;

endpackage

// File: rtl/exu_dp_if.sv
// Datapath interface between the sequencer (master) and the GPR file / ALU.
interface exu_dp_if;
    import exu_seq_pkg::*;

    logic [RV_GPR_AW-1:0]    gpr_raddr1;
    logic [RV_GPR_AW-1:0]    gpr_raddr2;
    logic [RV_XLEN-1:0]      gpr_rdata1;
    logic [RV_XLEN-1:0]      gpr_rdata2;
    logic                    gpr_wen;
    logic [RV_GPR_AW-1:0]    gpr_waddr;
    logic [RV_XLEN-1:0]      gpr_wdata;
    logic [RV_XLEN-1:0]      alu_src1;
    logic [RV_XLEN-1:0]      alu_src2;
    logic [ALU_OPC_SIZE-1:0] alu_opcode;
    logic [RV_XLEN-1:0]      alu_dst;

    modport master (
        output gpr_raddr1, gpr_raddr2, gpr_wen, gpr_waddr, gpr_wdata,
               alu_src1, alu_src2, alu_opcode,
        input  gpr_rdata1, gpr_rdata2, alu_dst
    );

    modport slave (
        input  gpr_raddr1, gpr_raddr2, gpr_wen, gpr_waddr, gpr_wdata,
               alu_src1, alu_src2, alu_opcode,
        output gpr_rdata1, gpr_rdata2, alu_dst
    );

endinterface

// File: rtl/exu_sb.sv
// Per-GPR busy scoreboard for outstanding loads; x0 is never busy and a set
// beats a clear of the same index in the same cycle.
module exu_sb
    import exu_seq_pkg::*;
#(
    parameter bit SB_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_vld,
    input  logic [RV_GPR_AW-1:0] set_idx,
    input  logic                 clr_vld,
    input  logic [RV_GPR_AW-1:0] clr_idx,
    input  logic [RV_GPR_AW-1:0] q_rs1_idx,
    input  logic [RV_GPR_AW-1:0] q_rs2_idx,
    input  logic [RV_GPR_AW-1:0] q_rd_idx,
    output logic                 q_rs1_busy,
    output logic                 q_rs2_busy,
    output logic                 q_rd_busy
);

    logic [RV_GPR_N-1:0] w_busy;

    assign w_busy[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < RV_GPR_N; gi++) begin : g_bit
            if (SB_EN) begin : g_en
                logic r_busy;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_busy <= 1'b0;
                    end else if (set_vld && (set_idx == RV_GPR_AW'(gi))) begin
                        r_busy <= 1'b1;
                    end else if (clr_vld && (clr_idx == RV_GPR_AW'(gi))) begin
                        r_busy <= 1'b0;
                    end
                end
                assign w_busy[gi] = r_busy;
            end else begin : g_dis
                assign w_busy[gi] = 1'b0;
            end
        end
    endgenerate

    assign q_rs1_busy = w_busy[q_rs1_idx];
    assign q_rs2_busy = w_busy[q_rs2_idx];
    assign q_rd_busy  = w_busy[q_rd_idx];

endmodule

// File: rtl/exu_seq.sv
// Single-issue execute sequencer: accept -> EXEC -> WB, sharing the single
// GPR write port with LSU load returns.
module exu_seq
    import exu_seq_pkg::*;
#(
    parameter bit SB_EN  = 1'b1,
    parameter bit RR_ARB = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    uop_vld,
    output logic                    uop_rdy,
    input  logic [ALU_OPC_SIZE-1:0] uop_opc,
    input  logic [RV_GPR_AW-1:0]    uop_rs1,
    input  logic [RV_GPR_AW-1:0]    uop_rs2,
    input  logic [RV_GPR_AW-1:0]    uop_rd,
    input  logic [RV_XLEN-1:0]      uop_imm,
    input  logic                    uop_use_imm,
    input  logic                    uop_wen,
    input  logic                    ld_req_vld,
    input  logic [RV_GPR_AW-1:0]    ld_req_rd,
    input  logic                    ld_vld,
    output logic                    ld_rdy,
    input  logic [RV_GPR_AW-1:0]    ld_rd,
    input  logic [RV_XLEN-1:0]      ld_data,
    output logic                    done_vld,
    output logic [RV_XLEN-1:0]      done_data,
    exu_dp_if.master                dp_op
);

    exu_seq_state_e r_state;
    exu_seq_state_e w_state_next;
    exu_uop_t       r_uop;
    exu_uop_t       w_uop_in;
    logic [RV_XLEN-1:0] r_result;
    exu_arb_win_e   r_rr_last;
    exu_arb_win_e   w_winner;

    logic w_busy_rs1, w_busy_rs2, w_busy_rd;
    logic w_hazard, w_accept, w_wb_req, w_conflict;
    logic w_alu_gnt, w_ld_gnt, w_retire;

    exu_sb #(.SB_EN(SB_EN)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_vld    (ld_req_vld),
        .set_idx    (ld_req_rd),
        .clr_vld    (w_ld_gnt),
        .clr_idx    (ld_rd),
        .q_rs1_idx  (uop_rs1),
        .q_rs2_idx  (uop_rs2),
        .q_rd_idx   (uop_rd),
        .q_rs1_busy (w_busy_rs1),
        .q_rs2_busy (w_busy_rs2),
        .q_rd_busy  (w_busy_rd)
    );

    assign w_uop_in = '{opc: uop_opc, rs1: uop_rs1, rs2: uop_rs2, rd: uop_rd,
                        imm: uop_imm, use_imm: uop_use_imm, wen: uop_wen};

    assign w_hazard   = w_busy_rs1 | (w_busy_rs2 & ~uop_use_imm) | (w_busy_rd & uop_wen);
    assign w_accept   = (r_state == IDLE) & uop_vld & uop_rdy;
    assign w_wb_req   = (r_state == WB) & r_uop.wen & (r_uop.rd != '0);
    assign w_conflict = w_wb_req & ld_vld;
    // Winner only matters on a conflict; fixed-priority builds always pick the load.
    assign w_winner   = (RR_ARB && (r_rr_last == WIN_LD)) ? WIN_ALU : WIN_LD;
    assign w_alu_gnt  = w_wb_req & (~ld_vld | (w_winner == WIN_ALU));
    assign w_ld_gnt   = rst_n & ld_vld & (~w_wb_req | (w_winner == WIN_LD));
    assign w_retire   = (r_state == WB) & (~w_wb_req | w_alu_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_uop     <= '0;
            r_result  <= '0;
            r_rr_last <= WIN_ALU;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_uop <= w_uop_in;
            end
            if (r_state == EXEC) begin
                r_result <= dp_op.alu_dst;
            end
            if (w_conflict) begin
                r_rr_last <= w_winner;
            end
        end
    end

    always_comb begin
        w_state_next       = r_state;
        uop_rdy            = 1'b0;
        ld_rdy             = w_ld_gnt;
        done_vld           = 1'b0;
        done_data          = '0;
        dp_op.gpr_raddr1   = '0;
        dp_op.gpr_raddr2   = '0;
        dp_op.alu_src1     = '0;
        dp_op.alu_src2     = '0;
        dp_op.alu_opcode   = ALU_ADD;
        dp_op.gpr_wen      = 1'b0;
        dp_op.gpr_waddr    = '0;
        dp_op.gpr_wdata    = '0;
        case (r_state)
            IDLE: begin
                uop_rdy = rst_n & ~w_hazard;
                if (uop_vld && uop_rdy) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                dp_op.gpr_raddr1 = r_uop.rs1;
                dp_op.gpr_raddr2 = r_uop.rs2;
                dp_op.alu_src1   = dp_op.gpr_rdata1;
                dp_op.alu_src2   = r_uop.use_imm ? r_uop.imm : dp_op.gpr_rdata2;
                dp_op.alu_opcode = r_uop.opc;
                w_state_next     = WB;
            end
            WB: begin
                if (w_retire) begin
                    done_vld     = 1'b1;
                    done_data    = r_result;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (w_alu_gnt) begin
            dp_op.gpr_wen   = 1'b1;
            dp_op.gpr_waddr = r_uop.rd;
            dp_op.gpr_wdata = r_result;
        end else if (w_ld_gnt) begin
            dp_op.gpr_wen   = (ld_rd != '0);
            dp_op.gpr_waddr = ld_rd;
            dp_op.gpr_wdata = ld_data;
        end
    end

    // A load must not target the destination of the op currently in flight.
    a_no_ld_to_inflight_rd: assert property (@(posedge clk) disable iff (!rst_n)
        !(ld_req_vld && (r_state != IDLE) && r_uop.wen &&
          (ld_req_rd == r_uop.rd) && (ld_req_rd != '0)));

endmodule

// File: tb/tb_exu_seq.sv
// Directed bench for exu_seq: a round-robin instance (A) and a load-priority
// instance (B) share stimulus; each has its own GPR file and ALU model.
module tb_exu_seq;
    import exu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic                    uop_vld = 1'b0;
    logic [ALU_OPC_SIZE-1:0] uop_opc = '0;
    logic [RV_GPR_AW-1:0]    uop_rs1 = '0, uop_rs2 = '0, uop_rd = '0;
    logic [RV_XLEN-1:0]      uop_imm = '0;
    logic                    uop_use_imm = 1'b0, uop_wen = 1'b0;
    logic                    ld_req_vld = 1'b0;
    logic [RV_GPR_AW-1:0]    ld_req_rd = '0;
    logic                    ld_vld = 1'b0;
    logic [RV_GPR_AW-1:0]    ld_rd = '0;
    logic [RV_XLEN-1:0]      ld_data = '0;

    logic uop_rdy_a, ld_rdy_a, done_vld_a;
    logic uop_rdy_b, ld_rdy_b, done_vld_b;
    logic [RV_XLEN-1:0] done_data_a, done_data_b;

    int checks = 0;
    int errors = 0;

    exu_dp_if dp_a ();
    exu_dp_if dp_b ();

    logic [RV_XLEN-1:0] rf_a [RV_GPR_N];
    logic [RV_XLEN-1:0] rf_b [RV_GPR_N];

    always #5 clk = ~clk;

    exu_seq #(.SB_EN(1'b1), .RR_ARB(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .uop_vld(uop_vld), .uop_rdy(uop_rdy_a),
        .uop_opc(uop_opc), .uop_rs1(uop_rs1), .uop_rs2(uop_rs2), .uop_rd(uop_rd),
        .uop_imm(uop_imm), .uop_use_imm(uop_use_imm), .uop_wen(uop_wen),
        .ld_req_vld(ld_req_vld), .ld_req_rd(ld_req_rd), .ld_vld(ld_vld),
        .ld_rdy(ld_rdy_a), .ld_rd(ld_rd), .ld_data(ld_data),
        .done_vld(done_vld_a), .done_data(done_data_a), .dp_op(dp_a)
    );

    exu_seq #(.SB_EN(1'b1), .RR_ARB(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .uop_vld(uop_vld), .uop_rdy(uop_rdy_b),
        .uop_opc(uop_opc), .uop_rs1(uop_rs1), .uop_rs2(uop_rs2), .uop_rd(uop_rd),
        .uop_imm(uop_imm), .uop_use_imm(uop_use_imm), .uop_wen(uop_wen),
        .ld_req_vld(ld_req_vld), .ld_req_rd(ld_req_rd), .ld_vld(ld_vld),
        .ld_rdy(ld_rdy_b), .ld_rd(ld_rd), .ld_data(ld_data),
        .done_vld(done_vld_b), .done_data(done_data_b), .dp_op(dp_b)
    );

    function automatic logic [RV_XLEN-1:0] alu_f(input logic [ALU_OPC_SIZE-1:0] op,
                                                 input logic [RV_XLEN-1:0] a,
                                                 input logic [RV_XLEN-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [RV_XLEN-1:0] rf_init(input int idx);
        case (idx)
            1:       return 32'd5;
            2:       return 32'd20;
            4:       return 32'd3;
            default: return 32'd0;
        endcase
    endfunction

    assign dp_a.gpr_rdata1 = rf_a[dp_a.gpr_raddr1];
    assign dp_a.gpr_rdata2 = rf_a[dp_a.gpr_raddr2];
    assign dp_a.alu_dst    = alu_f(dp_a.alu_opcode, dp_a.alu_src1, dp_a.alu_src2);
    assign dp_b.gpr_rdata1 = rf_b[dp_b.gpr_raddr1];
    assign dp_b.gpr_rdata2 = rf_b[dp_b.gpr_raddr2];
    assign dp_b.alu_dst    = alu_f(dp_b.alu_opcode, dp_b.alu_src1, dp_b.alu_src2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RV_GPR_N; i++) begin
                rf_a[i] <= rf_init(i);
                rf_b[i] <= rf_init(i);
            end
        end else begin
            if (dp_a.gpr_wen && dp_a.gpr_waddr != '0) rf_a[dp_a.gpr_waddr] <= dp_a.gpr_wdata;
            if (dp_b.gpr_wen && dp_b.gpr_waddr != '0) rf_b[dp_b.gpr_waddr] <= dp_b.gpr_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_uop(input logic [ALU_OPC_SIZE-1:0] opc, input logic [RV_GPR_AW-1:0] rs1,
                           input logic [RV_GPR_AW-1:0] rs2, input logic [RV_GPR_AW-1:0] rd,
                           input logic [RV_XLEN-1:0] imm, input logic use_imm, input logic wen);
        uop_vld = 1'b1;
        uop_opc = opc;
        uop_rs1 = rs1;
        uop_rs2 = rs2;
        uop_rd = rd;
        uop_imm = imm;
        uop_use_imm = use_imm;
        uop_wen = wen;
    endtask

    initial begin
        // Reset with a pending load and micro-op on the inputs
        #1 rst_n = 1'b0;
        ld_vld = 1'b1; ld_rd = 5'd4; ld_data = 32'h55;
        set_uop(ALU_SUB, 5'd1, 5'd2, 5'd3, 32'd9, 1'b0, 1'b1);
        #3;
        chk("rst_uop_rdy",   32'(uop_rdy_a), 32'd0);
        chk("rst_ld_rdy",    32'(ld_rdy_a), 32'd0);
        chk("rst_done_vld",  32'(done_vld_a), 32'd0);
        chk("rst_done_data", done_data_a, 32'd0);
        chk("rst_gpr_wen",   32'(dp_a.gpr_wen), 32'd0);
        chk("rst_gpr_waddr", 32'(dp_a.gpr_waddr), 32'd0);
        chk("rst_gpr_wdata", dp_a.gpr_wdata, 32'd0);
        chk("rst_raddr1",    32'(dp_a.gpr_raddr1), 32'd0);
        chk("rst_alu_opc",   32'(dp_a.alu_opcode), 32'(ALU_ADD));
        $display("reset phase checked");
        uop_vld = 1'b0; ld_vld = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // ADD x1(5) + imm 7 -> x3
        set_uop(ALU_ADD, 5'd1, 5'd0, 5'd3, 32'd7, 1'b1, 1'b1);
        #2 chk("t1_accept_rdy", 32'(uop_rdy_a), 32'd1);
        tick(); uop_vld = 1'b0;
        #2;
        chk("t1_exec_raddr1", 32'(dp_a.gpr_raddr1), 32'd1);
        chk("t1_exec_src1", dp_a.alu_src1, 32'd5);
        chk("t1_exec_src2", dp_a.alu_src2, 32'd7);
        chk("t1_exec_rdy", 32'(uop_rdy_a), 32'd0);
        chk("t1_exec_done", 32'(done_vld_a), 32'd0);
        tick(); #2;
        chk("t1_wb_done", 32'(done_vld_a), 32'd1);
        chk("t1_wb_data", done_data_a, 32'd12);
        chk("t1_wb_wen", 32'(dp_a.gpr_wen), 32'd1);
        chk("t1_wb_waddr", 32'(dp_a.gpr_waddr), 32'd3);
        chk("t1_wb_wdata", dp_a.gpr_wdata, 32'd12);
        tick(); #2;
        chk("t1_idle_rdy", 32'(uop_rdy_a), 32'd1);
        chk("t1_idle_done", 32'(done_vld_a), 32'd0);
        $display("uop ADD x1+7 -> x3 done_data=%0d", 12);

        // SUB x2(20) - x4(3) to rd=0: retires without a write
        set_uop(ALU_SUB, 5'd2, 5'd4, 5'd0, 32'd0, 1'b0, 1'b1);
        #2 chk("t2_accept_rdy", 32'(uop_rdy_a), 32'd1);
        tick(); uop_vld = 1'b0;
        #2;
        chk("t2_exec_src2", dp_a.alu_src2, 32'd3);
        chk("t2_exec_wen", 32'(dp_a.gpr_wen), 32'd0);
        tick(); #2;
        chk("t2_wb_done", 32'(done_vld_a), 32'd1);
        chk("t2_wb_data", done_data_a, 32'd17);
        chk("t2_wb_wen", 32'(dp_a.gpr_wen), 32'd0);
        tick();
        $display("uop SUB x2-x4 -> x0 done_data=%0d", 17);

        // Load to x5 outstanding: reader of x5 stalls until the return
        ld_req_vld = 1'b1; ld_req_rd = 5'd5;
        tick(); ld_req_vld = 1'b0;
        set_uop(ALU_ADD, 5'd5, 5'd3, 5'd6, 32'd0, 1'b0, 1'b1);
        #2 chk("t3_stall0", 32'(uop_rdy_a), 32'd0);
        tick(); #2 chk("t3_stall1", 32'(uop_rdy_a), 32'd0);
        ld_vld = 1'b1; ld_rd = 5'd5; ld_data = 32'h1234;
        #1;
        chk("t3_ld_rdy", 32'(ld_rdy_a), 32'd1);
        chk("t3_ld_wen", 32'(dp_a.gpr_wen), 32'd1);
        chk("t3_ld_waddr", 32'(dp_a.gpr_waddr), 32'd5);
        chk("t3_ld_wdata", dp_a.gpr_wdata, 32'h1234);
        chk("t3_ld_cycle_rdy", 32'(uop_rdy_a), 32'd0);
        tick(); ld_vld = 1'b0;
        #2 chk("t3_release_rdy", 32'(uop_rdy_a), 32'd1);
        tick(); uop_vld = 1'b0;
        #2 chk("t3_exec_src1", dp_a.alu_src1, 32'h1234);
        tick(); #2;
        chk("t3_wb_data", done_data_a, 32'h1240);
        chk("t3_wb_waddr", 32'(dp_a.gpr_waddr), 32'd6);
        tick();
        $display("load x5=0x1234 then uop x5+x3 -> x6 done_data=0x%0h", 32'h1240);

        // Round-robin: first collision goes to the load, second to the ALU
        set_uop(ALU_ADD, 5'd1, 5'd0, 5'd8, 32'd1, 1'b1, 1'b1);
        tick(); uop_vld = 1'b0;
        tick();
        ld_vld = 1'b1; ld_rd = 5'd9; ld_data = 32'hAA;
        #2;
        chk("t4a_ld_rdy", 32'(ld_rdy_a), 32'd1);
        chk("t4a_done", 32'(done_vld_a), 32'd0);
        chk("t4a_waddr", 32'(dp_a.gpr_waddr), 32'd9);
        tick(); ld_vld = 1'b0;
        #2;
        chk("t4a_alu_done", 32'(done_vld_a), 32'd1);
        chk("t4a_alu_ld_rdy", 32'(ld_rdy_a), 32'd0);
        chk("t4a_alu_waddr", 32'(dp_a.gpr_waddr), 32'd8);
        chk("t4a_alu_wdata", dp_a.gpr_wdata, 32'd6);
        tick();
        $display("collision 1: load x9 first, then ALU x8=%0d", 6);
        set_uop(ALU_ADD, 5'd1, 5'd0, 5'd10, 32'd2, 1'b1, 1'b1);
        tick(); uop_vld = 1'b0;
        tick();
        ld_vld = 1'b1; ld_rd = 5'd11; ld_data = 32'hBB;
        #2;
        chk("t4b_alu_done", 32'(done_vld_a), 32'd1);
        chk("t4b_ld_rdy", 32'(ld_rdy_a), 32'd0);
        chk("t4b_alu_waddr", 32'(dp_a.gpr_waddr), 32'd10);
        chk("t4b_alu_wdata", dp_a.gpr_wdata, 32'd7);
        tick(); #2;
        chk("t4b_ld_rdy_next", 32'(ld_rdy_a), 32'd1);
        chk("t4b_ld_waddr", 32'(dp_a.gpr_waddr), 32'd11);
        tick(); ld_vld = 1'b0;
        $display("collision 2: ALU x10=%0d first, then load x11", 7);

        // Load-priority instance: load wins three collisions in a row
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        set_uop(ALU_ADD, 5'd1, 5'd0, 5'd12, 32'd3, 1'b1, 1'b1);
        #2 chk("t5_accept_rdy", 32'(uop_rdy_b), 32'd1);
        tick(); uop_vld = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            ld_vld = 1'b1; ld_rd = 5'd13; ld_data = 32'(k + 1);
            #2;
            chk("t5_ld_rdy", 32'(ld_rdy_b), 32'd1);
            chk("t5_alu_held", 32'(done_vld_b), 32'd0);
            chk("t5_ld_wdata", dp_b.gpr_wdata, 32'(k + 1));
            tick();
        end
        ld_vld = 1'b0;
        #2;
        chk("t5_alu_done", 32'(done_vld_b), 32'd1);
        chk("t5_alu_waddr", 32'(dp_b.gpr_waddr), 32'd12);
        chk("t5_alu_wdata", dp_b.gpr_wdata, 32'd8);
        tick(); #2 chk("t5_idle_done", 32'(done_vld_b), 32'd0);
        $display("fixed priority: 3 loads then ALU x12=%0d", 8);

        // Reset while in EXEC with x7 busy
        ld_req_vld = 1'b1; ld_req_rd = 5'd7;
        tick(); ld_req_vld = 1'b0;
        set_uop(ALU_ADD, 5'd1, 5'd0, 5'd2, 32'd0, 1'b1, 1'b1);
        #2 chk("t6_accept_rdy", 32'(uop_rdy_a), 32'd1);
        tick(); uop_vld = 1'b0;
        #1 chk("t6_in_exec", 32'(dp_a.gpr_raddr1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_raddr1", 32'(dp_a.gpr_raddr1), 32'd0);
        chk("t6_rst_src1", dp_a.alu_src1, 32'd0);
        chk("t6_rst_done", 32'(done_vld_a), 32'd0);
        chk("t6_rst_wen", 32'(dp_a.gpr_wen), 32'd0);
        chk("t6_rst_rdy", 32'(uop_rdy_a), 32'd0);
        tick(); rst_n = 1'b1;
        set_uop(ALU_ADD, 5'd7, 5'd7, 5'd14, 32'd0, 1'b0, 1'b1);
        #2;
        chk("t6_no_stall", 32'(uop_rdy_a), 32'd1);
        chk("t6_idle_wen", 32'(dp_a.gpr_wen), 32'd0);
        tick(); uop_vld = 1'b0;
        #2;
        chk("t6_exec_wen", 32'(dp_a.gpr_wen), 32'd0);
        chk("t6_exec_done", 32'(done_vld_a), 32'd0);
        tick(); #2;
        chk("t6_wb_done", 32'(done_vld_a), 32'd1);
        chk("t6_wb_waddr", 32'(dp_a.gpr_waddr), 32'd14);
        chk("t6_wb_data", done_data_a, 32'd0);
        tick();
        $display("reset in EXEC, then uop x7+x7 -> x14 accepted without stall");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exu_seq.md
Name: exu_seq

Overview:
- Single-issue execute sequencer and master of exu_dp_if.
- Accepts decoded ALU micro-ops from the decoder over a valid/ready handshake, sequences GPR read, ALU operation and GPR writeback.
- Arbitrates the single GPR write port between ALU results and load-data returns from the LSU.
- Holds a per-register busy scoreboard for outstanding loads so that micro-ops never read a stale GPR.

Parameters:
- SB_EN, 1, 1 enables the load scoreboard; 0 makes every busy bit read as 0 (for LSU-less builds).
- RR_ARB, 1, 1 = round-robin write-port arbitration; 0 = load data always has priority.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- uop_vld  input  1  decoded micro-op valid.
- uop_rdy  output  1  sequencer can accept a micro-op.
- uop_opc  input  ALU_OPC_SIZE  ALU opcode.
- uop_rs1, uop_rs2, uop_rd  input  RV_GPR_AW each  register indices.
- uop_imm  input  RV_XLEN  immediate, sign-extended by the decoder.
- uop_use_imm  input  1  src2 = imm instead of rs2.
- uop_wen  input  1  result is written to rd.
- ld_req_vld  input  1  LSU issued a load; marks ld_req_rd busy.
- ld_req_rd  input  RV_GPR_AW  load destination.
- ld_vld  input  1  load data return valid.
- ld_rdy  output  1  load data accepted this cycle.
- ld_rd  input  RV_GPR_AW  return destination.
- ld_data  input  RV_XLEN  return data.
- done_vld  output  1  one-cycle pulse: micro-op retired.
- done_data  output  RV_XLEN  ALU result of the retired op.
- dp_op  exu_dp_if.master  -  datapath interface (GPR ports, ALU ports).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy[*]=0; rr_last=ALU; uop_rdy=0 while in reset; ld_rdy=0; done_vld=0; done_data=0; gpr_wen=0; alu_opcode=ADD; all address and data outputs are 0.
- Reset mid-operation discards any latched micro-op and the scoreboard. No writeback occurs after reset.
- FSM states: IDLE, EXEC, WB.
- IDLE
  - uop_rdy = 1 only if no hazard. A hazard exists if busy[rs1], or busy[rs2] with !use_imm, or busy[rd] with wen (WAW).
  - On uop_vld & uop_rdy: latch all uop fields and go to EXEC.
- EXEC (exactly 1 cycle)
  - Drive gpr_raddr1=rs1 and gpr_raddr2=rs2.
  - Drive alu_src1=gpr_rdata1, alu_src2=use_imm ? imm : gpr_rdata2, alu_opcode=opc.
  - Register alu_dst into the result register and go to WB.
- WB
  - Request the write port when wen & rd!=0. Otherwise retire immediately (done_vld=1, no gpr_wen) and return to IDLE.
  - Retirement on the grant cycle: gpr_waddr=rd, gpr_wdata=result, gpr_wen=1, done_vld=1, done_data=result; return to IDLE.
- Minimum latency: accept at cycle N, EXEC at N+1, writeback/done at N+2. The next accept is possible in cycle N+3 (IDLE). No back-to-back overlap.
- Load return path
  - ld_rdy=1 when ld_vld and the load wins arbitration.
  - On acceptance: gpr_wen=(ld_rd!=0), gpr_waddr=ld_rd, gpr_wdata=ld_data, and clear busy[ld_rd].
- Arbitration, only when WB requests and ld_vld are active in the same cycle:
  - RR_ARB=1: grant goes to the requester that is not rr_last; rr_last updates to the winner.
  - RR_ARB=0: load wins.
  - The loser holds (WB stays; ld_rdy=0).
  - With no conflict, either requester is granted at once.
- Scoreboard
  - ld_req_vld sets busy[ld_req_rd], ignored for rd=0.
  - Simultaneous set and clear of the same index: set wins (new load outstanding).
  - busy[0] is constantly 0.
  - A load issued to a register that a micro-op in EXEC/WB will write is a decoder ordering error. It is not checked; assertion only.
- The hazard check uses current-cycle busy bits, so a clear in cycle T allows acceptance in cycle T+1.
- Widths: all data is RV_XLEN. Results are taken unmodified from alu_dst; no sign handling in this block.

Decomposition:
- Shared package exu/seq.svh:
  - exu_seq_state_e {IDLE, EXEC, WB}.
  - arbitration winner enum {WIN_ALU, WIN_LD}.
  - latched-uop struct (opc, rs1, rs2, rd, imm, use_imm, wen).
- Sub-module exu_sb: busy-bit scoreboard with set/clear/query ports (3 query ports: rs1, rs2, rd).
- Arbitration stays inline in exu_seq.

Test Plan:
- Reset, then uop ADD rs1=1 (x1=5), use_imm, imm=7, rd=3 -> done_vld at accept+2, done_data=12, gpr_wen with waddr=3, wdata=12; uop_rdy returns 1 at accept+3.
- uop SUB, wen=1, rd=0 -> done_vld=1, done_data=result, gpr_wen stays 0 throughout.
- ld_req_vld rd=5, then uop reading rs1=5 -> uop_rdy=0; ld_vld rd=5 data=0x1234 accepted -> next cycle uop accepted, result uses 0x1234.
- WB and ld_vld collide with RR_ARB=1, rr_last=ALU -> load granted first (ld_rdy=1), ALU writes the following cycle. A second collision -> ALU is granted.
- Same collision with RR_ARB=0, repeated 3 times -> load wins every time; ALU retires only when ld_vld drops.
- rst_n asserted while in EXEC with busy[7]=1 -> all outputs return to reset values immediately. After release, a uop reading x7 is accepted with no stall and no stray gpr_wen.
